// File: rtl/vedic_mac_accumulator.sv
// Streaming multiply-accumulate stage: registered operands, Vedic 32x32 product,
// wide accumulator with sticky overflow, and a valid/ready burst-result port.

module vedic_mul #(
    parameter int W = 32
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);
    generate
        if (W == 2) begin : g_base
            logic c_s;
            assign c_s    = (a_i[1] & b_i[0]) & (a_i[0] & b_i[1]);
            assign p_o[0] = a_i[0] & b_i[0];
            assign p_o[1] = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
            assign p_o[2] = (a_i[1] & b_i[1]) ^ c_s;
            assign p_o[3] = (a_i[1] & b_i[1]) & c_s;
        end else begin : g_rec
            localparam int H = W / 2;
            logic [W-1:0] pll_s;
            logic [W-1:0] plh_s;
            logic [W-1:0] phl_s;
            logic [W-1:0] phh_s;
            logic [W:0]   mid_s;

            vedic_mul #(.W(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(pll_s));
            vedic_mul #(.W(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(plh_s));
            vedic_mul #(.W(H)) u_hl (.a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(phl_s));
            vedic_mul #(.W(H)) u_hh (.a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(phh_s));

            // Vertical-and-crosswise: the two cross products land on the middle half.
            assign mid_s = {1'b0, plh_s} + {1'b0, phl_s};
            assign p_o   = {phh_s, pll_s} + {{(H-1){1'b0}}, mid_s, {H{1'b0}}};
        end
    endgenerate
endmodule

module vedic_multiplier_32x32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o
);
    vedic_mul #(.W(32)) u_core (.a_i(a_i), .b_i(b_i), .p_o(p_o));
endmodule

module vedic_mac_accumulator #(
    parameter int ACC_W = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [15:0]      out_count,
    output logic             overflow
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [31:0]        a_q, b_q;
    logic               s1_vld_q, s1_last_q;
    logic [63:0]        prod_q;
    logic               s2_vld_q, s2_last_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [63:0]        product_s;
    logic [ACC_W:0]     sum_s;
    logic               accept_s;
    logic               handshake_s;

    assign accept_s    = in_valid & in_ready_q;
    assign handshake_s = out_valid_q & out_ready;

    vedic_multiplier_32x32 u_mul (.a_i(a_q), .b_i(b_q), .p_o(product_s));

    // Burst control: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept_s && in_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (s2_vld_q && s2_last_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (handshake_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Accumulator, saturating term count and sticky carry-out.
    always_comb begin
        sum_s = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (handshake_s) begin
            acc_d = {ACC_W{1'b0}};
            cnt_d = 16'd0;
            ovf_d = 1'b0;
        end else if (s2_vld_q) begin
            acc_d = sum_s[ACC_W-1:0];
            ovf_d = ovf_q | sum_s[ACC_W];
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // State and handshake flags; in_ready is held low for the whole reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_RUN);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    // S1 operand and S2 product pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            prod_q    <= 64'd0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
        end else begin
            s1_vld_q <= accept_s;
            s2_vld_q <= s1_vld_q;
            if (accept_s) begin
                a_q       <= a;
                b_q       <= b;
                s1_last_q <= in_last;
            end
            if (s1_vld_q) begin
                prod_q    <= product_s;
                s2_last_q <= s1_last_q;
            end
        end
    end

    // S3 accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= {ACC_W{1'b0}};
            cnt_q <= 16'd0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign out_count = cnt_q;
    assign overflow  = ovf_q;
endmodule

// File: doc/vedic_mac_accumulator.md
# vedic_mac_accumulator

Streaming multiply-accumulate stage built around `vedic_multiplier_32x32`. It accepts a burst of unsigned 32x32 operand pairs over a valid/ready handshake and registers each 64-bit product. It sums the products into a wide accumulator and presents the burst total, term count and overflow flag on a valid/ready output once the burst's last term has been accumulated. It sits directly downstream of the multiplier, turning its combinational products into a pipelined dot-product result.

## Interface

- `ACC_W`, 80, accumulator/result width in bits; legal range is ACC_W ≥ 64; 16 guard bits by default.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operand pair `a`/`b` (and `in_last`) is valid.
- `in_ready`  output  1  block can accept an operand pair this cycle.
- `a`  input  32  unsigned multiplicand.
- `b`  input  32  unsigned multiplier.
- `in_last`  input  1  this pair is the final term of the burst; sampled only on accept.
- `out_valid`  output  1  `acc_out`/`out_count`/`overflow` hold a finished burst result.
- `out_ready`  input  1  consumer takes the result.
- `acc_out`  output  ACC_W  burst sum of products, modulo 2^ACC_W.
- `out_count`  output  16  number of terms in the burst, saturating at 65535.
- `overflow`  output  1  sticky; a carry out of bit ACC_W-1 occurred during this burst.

## Operation

- Accept = `in_valid & in_ready` at a rising edge; no other condition loads operands.
- Three-stage pipeline:
  - **S1:** operand registers, loaded on accept, with a valid bit.
  - **S2:** product register, loaded from `vedic_multiplier_32x32` fed by S1, with a valid bit.
  - **S3:** accumulator update when the S2 valid bit is set.
- Arithmetic:
  - Product is zero-extended to ACC_W.
  - `acc_next = acc + product` modulo 2^ACC_W.
  - `overflow` is set on the carry out and stays set until the result handshake.
  - `out_count` increments per accumulated term and saturates at 65535.
- FSM states:
  - **RUN** (`in_ready`=1): accepts terms. On accept with `in_last`=1, go to DRAIN.
  - **DRAIN** (`in_ready`=0): wait until the last term's S2 valid bit is consumed by the accumulator, then go to DONE on that same edge.
  - **DONE** (`in_ready`=0, `out_valid`=1): hold all outputs stable. On `out_valid & out_ready`, clear the accumulator, `out_count` and `overflow`, and go to RUN.
- Bubbles (`in_valid`=0) in RUN are allowed. Pipeline valid bits prevent spurious accumulation.
- `in_last` with `in_valid`=0, or while `in_ready`=0, is ignored.
- A burst of one term is legal.
- Empty bursts do not exist: a result is produced only after an accepted `in_last`.
- Reset (asynchronous, any state, including mid-burst or in DONE):
  - State goes to RUN.
  - All pipeline valid bits, accumulator, `out_count`, `overflow` and `out_valid` go to 0.
  - `in_ready` is 0 while `rst` is high and 1 from the first cycle after release.
  - The partial burst is discarded.

## Timing

- Reset values: `in_ready`=0 during reset, then 1; `out_valid`=0; `acc_out`=0; `out_count`=0; `overflow`=0.
- Throughput is 1 term/cycle within a burst.
- Latency:
  - Last term accepted at edge E0.
  - Product registered at E1.
  - Accumulated at E2.
  - `out_valid`=1 and the final `acc_out` are visible immediately after E2.
- `in_ready` falls immediately after E0 and stays low through DONE.
- `in_ready` returns high the cycle after the result handshake edge. The earliest next accept is one edge after the handshake.
- `out_valid` falls in the cycle after the handshake edge.
- If `out_ready` is high at E2, the handshake occurs at the next edge, E3; no combinational path exists from `out_ready` to `out_valid`.
- `in_ready` depends on state only: no combinational path from `in_valid` or `out_ready`.
- Outputs are held stable while `out_valid`=1 and `out_ready`=0.

## Test plan

- **Single term:** accept a=3, b=5, `in_last`=1 at E0 → `out_valid` after E2 with `acc_out`=15, `out_count`=1, `overflow`=0; `in_ready`=0 from E0 until the handshake.
- **Back-to-back burst:** 4 consecutive accepts of a=b=0xFFFFFFFF, last on the 4th → `acc_out`=0x3_FFFF_FFF8_0000_0004, `out_count`=4, `overflow`=0; `out_valid` 2 edges after the 4th accept.
- **Bubbles and backpressure:** terms (2,3), idle, (4,5) last; hold `out_ready`=0 for 5 cycles → `acc_out`=26 and `out_count`=2 stay stable with `in_ready`=0; raise `out_ready` → handshake, then `in_ready`=1 next cycle and the next burst starts from zero.
- **Overflow (ACC_W=64):** two terms a=b=0xFFFFFFFF → `acc_out`=0xFFFF_FFFC_0000_0002, `overflow`=1; the following burst (1×1) → `acc_out`=1, `overflow`=0.
- **Reset mid-burst:** accept (7,7), (9,9), assert `rst` for 1 cycle before any last → all outputs 0; then burst (2,7) last → `acc_out`=14, `out_count`=1.
- **Ignored last:** `in_last`=1 with `in_valid`=0 during RUN, then (1,1) last → exactly one result, with `out_count`=1 covering only the accepted term.
